// File: rtl/cla_serial_subtractor_pkg.sv
// Shared definitions for the serial CLA subtractor: FSM state encoding and
// the number of bits consumed per clock.
package cla_serial_subtractor_pkg;

  localparam int CLA_SLICE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : cla_serial_subtractor_pkg

// File: rtl/cla_serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface cla_serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, borrow, ovf);
  modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif
endinterface : cla_serial_subtractor_if

// File: rtl/cla_serial_subtractor_slice.sv
// 2-bit carry-lookahead subtract slice: s = a + ~b + cin.
// Purely combinational; both carries come from p/g in two logic levels.
module cla_sub_slice_2bits (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  input  logic       cin_i,
  output logic [1:0] s_o,
  output logic       cout_o
);
  logic [1:0] b_n;
  logic [1:0] p;
  logic [1:0] g;
  logic       c1;

  assign b_n    = ~b_i;
  assign p      = a_i ^ b_n;
  assign g      = a_i & b_n;
  assign c1     = g[0] | (p[0] & cin_i);
  assign cout_o = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign s_o    = {p[1] ^ c1, p[0] ^ cin_i};
endmodule : cla_sub_slice_2bits

// File: rtl/cla_serial_subtractor.sv
// Multi-cycle two's-complement subtractor, diff = a - b, two bits per clock
// through a single 2-bit CLA slice with the carry chained between cycles.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module cla_serial_subtractor
  import cla_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  cla_serial_subtractor_if.slave  bus
);
  localparam int NSLICE = WIDTH / CLA_SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [1:0]       sum;
  logic             cout;
  logic [WIDTH-1:0] res_shift;

  // Operand registers shift right each cycle so the slice always sees bits [1:0].
  cla_sub_slice_2bits u_slice (
    .a_i    (a_q[1:0]),
    .b_i    (b_q[1:0]),
    .cin_i  (carry_q),
    .s_o    (sum),
    .cout_o (cout)
  );

  // New slice sum enters the result register from the MSB end.
  assign res_shift = (res_q >> CLA_SLICE_W) | (WIDTH'(sum) << (WIDTH - CLA_SLICE_W));

  // Next-state and datapath control.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    carry_d  = carry_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          res_d   = '0;
          carry_d = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> CLA_SLICE_W;
        b_d     = b_q >> CLA_SLICE_W;
        res_d   = res_shift;
        carry_d = cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d  = ST_DONE;
          diff_d   = res_shift;
          borrow_d = ~cout;
`ifdef SERIAL_SUB_OVF_EN
          // On the last slice a_q[1]/b_q[1] are the original operand MSBs.
          ovf_d    = (a_q[1] ^ b_q[1]) & (a_q[1] ^ sum[1]);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and visible results, synchronously reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Operand and partial-result shift registers.
  // NOTE: deliberately unreset; they are always loaded on an accepted start before use.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    res_q <= res_d;
  end

  assign bus.busy   = (state_q == ST_RUN);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule : cla_serial_subtractor

// File: tb/tb_cla_serial_subtractor.sv
// Self-checking bench for cla_serial_subtractor (WIDTH=8): directed cases,
// handshake corner cases and random operands against an arithmetic model.
// Checks ovf as well when built with SERIAL_SUB_OVF_EN.
module tb_cla_serial_subtractor;
  localparam int W   = 8;
  localparam int LAT = W / 2;

  logic clk = 1'b0;
  logic reset;

  cla_serial_subtractor_if #(.WIDTH(W)) bus ();

  cla_serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Results the DUT must currently be holding.
  logic [W-1:0] exp_diff   = '0;
  logic         exp_borrow = 1'b0;
  logic         exp_ovf    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    int r;
    r = (int'(a) - int'(b) + (1 << W)) % (1 << W);
    return W'(r);
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
    return int'(a) < int'(b);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, d;
    sa = int'($signed(a));
    sb = int'($signed(b));
    d  = sa - sb;
    return (d > (1 << (W - 1)) - 1) || (d < -(1 << (W - 1)));
  endfunction

  task automatic check_outputs(input string tag);
    check($sformatf("%s diff", tag), 32'(bus.diff), 32'(exp_diff));
    check($sformatf("%s borrow", tag), 32'(bus.borrow), 32'(exp_borrow));
`ifdef SERIAL_SUB_OVF_EN
    check($sformatf("%s ovf", tag), 32'(bus.ovf), 32'(exp_ovf));
`endif
  endtask

  // Present a start for one edge, then scramble the operand inputs.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    tick();
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
  endtask

  // Wait (bounded) for done; lat0/busy0 account for cycles already spent.
  task automatic wait_done(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input int lat0, input int busy0);
    int lat;
    int busy_n;
    lat    = lat0;
    busy_n = busy0;
    while (!bus.done && lat < 4 * LAT + 4) begin
      if (bus.busy) busy_n++;
      tick();
      lat++;
    end
    exp_diff   = ref_diff(av, bv);
    exp_borrow = ref_borrow(av, bv);
    exp_ovf    = ref_ovf(av, bv);
    check($sformatf("%s done", tag), 32'(bus.done), 32'd1);
    check($sformatf("%s latency", tag), 32'(lat), 32'(LAT));
    check($sformatf("%s busy cycles", tag), 32'(busy_n), 32'(LAT));
    check_outputs(tag);
  endtask

  // One cycle after done: pulse must be gone and results must hold.
  task automatic after_done(input string tag);
    tick();
    check($sformatf("%s done pulse width", tag), 32'(bus.done), 32'd0);
    check($sformatf("%s busy after done", tag), 32'(bus.busy), 32'd0);
    check_outputs($sformatf("%s hold", tag));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
    start_op(av, bv);
    wait_done(tag, av, bv, 0, 0);
    after_done(tag);
  endtask

  // Count done pulses over n idle cycles; none are expected.
  task automatic expect_quiet(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.done) pulses++;
    end
    check($sformatf("%s spurious done", tag), 32'(pulses), 32'd0);
    check_outputs($sformatf("%s quiet", tag));
  endtask

  logic [W-1:0] dir_a [7] = '{8'd100, 8'd37, 8'd0, 8'h80, 8'h05, 8'h5A, 8'hC3};
  logic [W-1:0] dir_b [7] = '{8'd37, 8'd100, 8'd0, 8'h01, 8'h03, 8'h5A, 8'h00};

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) tick();
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check_outputs("reset");
    reset = 1'b0;
    tick();

    // Directed operand pairs, including a==b, b==0 and signed overflow.
    for (int i = 0; i < 7; i++)
      run_op($sformatf("dir%0d", i), dir_a[i], dir_b[i]);

    // start re-asserted during RUN with different operands is ignored.
    start_op(8'd100, 8'd37);
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'h00;
    tick();
    bus.start = 1'b0;
    wait_done("ign", 8'd100, 8'd37, 1, 1);
    after_done("ign");
    expect_quiet("ign", 2 * LAT);

    // Reset in the 2nd RUN cycle aborts the operation.
    start_op(8'd200, 8'd17);
    tick();
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    exp_diff   = '0;
    exp_borrow = 1'b0;
    exp_ovf    = 1'b0;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check_outputs("abort");
    expect_quiet("abort", 2 * LAT);
    run_op("post-abort", 8'd100, 8'd37);

    // Back-to-back: new start presented during the DONE cycle.
    start_op(8'd100, 8'd37);
    wait_done("b2b first", 8'd100, 8'd37, 0, 0);
    start_op(8'd9, 8'd4);
    wait_done("b2b second", 8'd9, 8'd4, 0, 0);
    after_done("b2b second");

    // Random operands with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 10 == 0) rb = ra;
      run_op($sformatf("rnd%0d", i), ra, rb);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_cla_serial_subtractor
